// File: rtl/prince_sbox_cms_compress.sv
`default_nettype none
// ============================================================================
// Module   : prince_sbox_cms_compress
// Brief    : Two-stage elastic share-compression stage for the masked PRINCE
//            S-box. Eight expanded shares per output bit are registered
//            (glitch barrier), then XOR-compressed into three shares that
//            are registered again. A valid/ready handshake lets the round
//            controller stall the pipeline without loss or duplication.
// Build    : define REFRESH_EN to capture rnd alongside the shares and XOR
//            the fresh randomness r1/r2 into the compressed shares.
// Revision : 1.0 - initial release
// ============================================================================
module prince_sbox_cms_compress #(
    parameter int N_SBOX = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*N_SBOX-1:0]  in_shares,
    input  logic [8*N_SBOX-1:0]   rnd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*N_SBOX-1:0]   out_sh0,
    output logic [4*N_SBOX-1:0]   out_sh1,
    output logic [4*N_SBOX-1:0]   out_sh2
);

    // Width of one share word (one bit per S-box output bit).
    localparam int c_W = 4 * N_SBOX;

    // ------------------------------------------------------------------
    // Stage 1 state: raw expanded shares (and randomness) plus valid flag
    // ------------------------------------------------------------------
    logic               r_s1_v;
    logic [8*c_W-1:0]   r_s1_sh;

    // ------------------------------------------------------------------
    // Stage 2 state: compressed shares plus valid flag
    // ------------------------------------------------------------------
    logic               r_out_valid;
    logic [c_W-1:0]     r_out_sh0;
    logic [c_W-1:0]     r_out_sh1;
    logic [c_W-1:0]     r_out_sh2;

    // Handshake and datapath wires
    logic               w_s2_adv;
    logic               w_s1_load;
    logic               w_in_ready;
    logic [c_W-1:0]     w_sh [8];
    logic [c_W-1:0]     w_c0;
    logic [c_W-1:0]     w_c1;
    logic [c_W-1:0]     w_c2;

    // ------------------------------------------------------------------
    // Handshake. S2 advances when it holds nothing or is being drained;
    // S1 accepts when empty or when its content moves on this cycle.
    // in_ready therefore sees out_ready through a single gate level.
    // ------------------------------------------------------------------
    assign w_s2_adv   = r_s1_v && (!r_out_valid || out_ready);
    assign w_in_ready = !r_s1_v || w_s2_adv;
    assign w_s1_load  = in_valid && w_in_ready;

    // Stage 1 valid flag: set on accept, cleared when its data moves to S2
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_v <= 1'b1;
        end else if (w_s2_adv) begin
            r_s1_v <= 1'b0;
        end
    end

    // Stage 1 share register: whole word loads only on accept, else holds
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_sh <= '0;
        end else if (w_s1_load) begin
            r_s1_sh <= in_shares;
        end
    end

    // Split the registered share bus into the eight share words.
    for (genvar k = 0; k < 8; k++) begin : g_split
        assign w_sh[k] = r_s1_sh[k*c_W +: c_W];
    end

`ifdef REFRESH_EN
    logic [2*c_W-1:0]   r_s1_rnd;
    logic [c_W-1:0]     w_r1;
    logic [c_W-1:0]     w_r2;

    // Stage 1 randomness register: captured together with the shares
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_rnd <= '0;
        end else if (w_s1_load) begin
            r_s1_rnd <= rnd;
        end
    end

    assign w_r1 = r_s1_rnd[c_W-1:0];
    assign w_r2 = r_s1_rnd[2*c_W-1:c_W];

    // Refreshed compression: r1 and r2 each appear twice, so they cancel
    // in the recombined value while re-randomising every output share.
    always_comb begin
        w_c0 = w_sh[0] ^ w_sh[1] ^ w_sh[2] ^ w_r1;
        w_c1 = w_sh[3] ^ w_sh[4] ^ w_sh[5] ^ w_r2;
        w_c2 = w_sh[6] ^ w_sh[7] ^ w_r1 ^ w_r2;
    end
`else
    // Randomness is not consumed in this build.
    logic w_unused_rnd;
    assign w_unused_rnd = ^rnd;

    // Plain compression: fixed grouping of the eight shares into three
    always_comb begin
        w_c0 = w_sh[0] ^ w_sh[1] ^ w_sh[2];
        w_c1 = w_sh[3] ^ w_sh[4] ^ w_sh[5];
        w_c2 = w_sh[6] ^ w_sh[7];
    end
`endif

    // Stage 2 valid flag: set on advance, cleared after a drain with no refill
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Stage 2 share registers: all three load together or all hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_sh0 <= '0;
            r_out_sh1 <= '0;
            r_out_sh2 <= '0;
        end else if (w_s2_adv) begin
            r_out_sh0 <= w_c0;
            r_out_sh1 <= w_c1;
            r_out_sh2 <= w_c2;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_sh0   = r_out_sh0;
    assign out_sh1   = r_out_sh1;
    assign out_sh2   = r_out_sh2;

endmodule
`default_nettype wire

// File: tb/tb_prince_sbox_cms_compress.sv
`default_nettype none
// ============================================================================
// Module   : tb_prince_sbox_cms_compress
// Brief    : Scoreboard bench for prince_sbox_cms_compress (N_SBOX = 1).
//            Honours REFRESH_EN the same way as the design build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prince_sbox_cms_compress;

    localparam int N_SBOX = 1;
    localparam int W      = 4 * N_SBOX;

`ifdef REFRESH_EN
    localparam bit         REFRESH = 1'b1;
    localparam logic [3:0] K0 = 4'h2;
    localparam logic [3:0] K1 = 4'h4;
    localparam logic [3:0] K2 = 4'h0;
`else
    localparam bit         REFRESH = 1'b0;
    localparam logic [3:0] K0 = 4'h7;
    localparam logic [3:0] K1 = 4'hE;
    localparam logic [3:0] K2 = 4'hF;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [8*W-1:0] in_shares;
    logic [2*W-1:0] rnd;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_sh0;
    logic [W-1:0]   out_sh1;
    logic [W-1:0]   out_sh2;

    typedef struct {
        logic [W-1:0] c0;
        logic [W-1:0] c1;
        logic [W-1:0] c2;
        logic [W-1:0] xall;
        int           cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   occ      = 0;
    int   n_acc    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    prince_sbox_cms_compress #(.N_SBOX(N_SBOX)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_shares (in_shares),
        .rnd       (rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sh0   (out_sh0),
        .out_sh1   (out_sh1),
        .out_sh2   (out_sh2)
    );

    // Reference: group the eight shares 3/3/2, optionally fold in r1/r2.
    function automatic exp_t model(input logic [8*W-1:0] sh, input logic [2*W-1:0] r);
        logic [W-1:0] s [8];
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        exp_t e;
        for (int k = 0; k < 8; k++) s[k] = sh[k*W +: W];
        r1 = r[W-1:0];
        r2 = r[2*W-1:W];
        e.c0 = s[0] ^ s[1] ^ s[2];
        e.c1 = s[3] ^ s[4] ^ s[5];
        e.c2 = s[6] ^ s[7];
        if (REFRESH) begin
            e.c0 = e.c0 ^ r1;
            e.c1 = e.c1 ^ r2;
            e.c2 = e.c2 ^ r1 ^ r2;
        end
        e.xall = '0;
        for (int k = 0; k < 8; k++) e.xall = e.xall ^ s[k];
        e.cyc = 0;
        return e;
    endfunction

    function automatic logic [8*W-1:0] rand_shares();
        logic [8*W-1:0] v;
        for (int k = 0; k < 8; k++) v[k*W +: W] = W'($urandom);
        return v;
    endfunction

    function automatic logic [2*W-1:0] rand_rnd();
        logic [2*W-1:0] v;
        for (int k = 0; k < 2; k++) v[k*W +: W] = W'($urandom);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Acceptance side: checks in_ready against occupancy and queues expectations.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
            occ = 0;
        end else begin
            checks++;
            if (in_ready !== ((occ < 2) || out_ready)) begin
                failures++;
                $display("FAIL in_ready: got %b, expected %b (occupancy %0d)",
                         in_ready, ((occ < 2) || out_ready), occ);
            end
            if (occ == 2) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL out_valid_full: got %b, expected 1", out_valid);
                end
            end
            if (in_valid && in_ready) begin
                e     = model(in_shares, rnd);
                e.cyc = cyc;
                sb_q.push_back(e);
                n_acc++;
            end
            occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
        end
    end

    // Output monitor: pops and compares on every output transfer.
    logic         hold_prev = 1'b0;
    logic [W-1:0] p0, p1, p2;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_sh0 !== p0 || out_sh1 !== p1 || out_sh2 !== p2) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%b %h/%h/%h, expected v=1 %h/%h/%h",
                             out_valid, out_sh0, out_sh1, out_sh2, p0, p1, p2);
                end
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %h/%h/%h, expected no transfer",
                             out_sh0, out_sh1, out_sh2);
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if ({out_sh0, out_sh1, out_sh2} !== {e.c0, e.c1, e.c2}) begin
                        failures++;
                        $display("FAIL data: got %h/%h/%h, expected %h/%h/%h",
                                 out_sh0, out_sh1, out_sh2, e.c0, e.c1, e.c2);
                    end
                    checks++;
                    if ((out_sh0 ^ out_sh1 ^ out_sh2) !== e.xall) begin
                        failures++;
                        $display("FAIL recombine: got %h, expected %h",
                                 out_sh0 ^ out_sh1 ^ out_sh2, e.xall);
                    end
                    checks++;
                    if (cyc - e.cyc < 2) begin
                        failures++;
                        $display("FAIL latency: got %0d cycles, expected at least 2", cyc - e.cyc);
                    end
                end
            end
            hold_prev = out_valid && !out_ready;
            p0 = out_sh0;
            p1 = out_sh1;
            p2 = out_sh2;
        end
    end

    initial begin
        int base;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_shares = '0;
        rnd       = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);

        // Reset state
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_sh", 32'({out_sh0, out_sh1, out_sh2}), 32'd0);
        step();
        rst = 1'b0;

        // Known-answer transfer, latency exactly two cycles
        in_valid  = 1'b1;
        in_shares = 32'h9653_8421;
        rnd       = 8'hA5;
        @(negedge clk);
        chk("kat_accept", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("kat_not_early", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        chk("kat_valid", 32'(out_valid), 32'd1);
        chk("kat_sh0", 32'(out_sh0), 32'(K0));
        chk("kat_sh1", 32'(out_sh1), 32'(K1));
        chk("kat_sh2", 32'(out_sh2), 32'(K2));
        chk("kat_xor", 32'(out_sh0 ^ out_sh1 ^ out_sh2), 32'h6);
        step();

        // Back-to-back 16 transfers at full rate
        for (int i = 0; i < 19; i++) begin
            in_valid  = (i < 16);
            in_shares = rand_shares();
            rnd       = rand_rnd();
            @(negedge clk);
            if (i < 16) chk("b2b_in_ready", 32'(in_ready), 32'd1);
            if (i >= 2 && i < 18) chk("b2b_out_valid", 32'(out_valid), 32'd1);
            if (i == 18) chk("b2b_drained", 32'(out_valid), 32'd0);
            step();
        end
        in_valid = 1'b0;

        // Stall: two accepts, then full, then release
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_shares = rand_shares();
        rnd       = rand_rnd();
        @(negedge clk);
        chk("stall_acc0", 32'(in_ready), 32'd1);
        step();
        in_shares = rand_shares();
        rnd       = rand_rnd();
        @(negedge clk);
        chk("stall_acc1", 32'(in_ready), 32'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            in_shares = rand_shares();
            rnd       = rand_rnd();
            @(negedge clk);
            chk("stall_full_in_ready", 32'(in_ready), 32'd0);
            chk("stall_full_valid", 32'(out_valid), 32'd1);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_first", 32'(out_valid), 32'd1);
        step();
        @(negedge clk);
        chk("release_second", 32'(out_valid), 32'd1);
        step();
        @(negedge clk);
        chk("release_empty", 32'(out_valid), 32'd0);
        step();

        // Reset while both stages hold data
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_shares = rand_shares();
        step();
        in_shares = rand_shares();
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_sh", 32'({out_sh0, out_sh1, out_sh2}), 32'd0);
        step();

        // First transfer after reset
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_shares = 32'h9653_8421;
        rnd       = 8'hA5;
        step();
        in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("postrst_valid", 32'(out_valid), 32'd1);
        chk("postrst_sh", 32'({out_sh0, out_sh1, out_sh2}), 32'({K0, K1, K2}));
        step();

        // Random traffic with random stalls
        base = n_acc;
        for (int c = 0; c < 60000 && n_acc < base + 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_shares = rand_shares();
            rnd       = rand_rnd();
            step();
        end
        chk("random_transfers_done", 32'(n_acc >= base + 10000), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        chk("drain_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
